// File: rtl/sar_seq_pkg.sv
// Shared types and widths for the SAR ADC scan sequencer.
// Holds the scan FSM state encoding and the internal counter widths.
package sar_seq_pkg;

   localparam int PERIOD_W     = 16;
   localparam int SETTLE_CNT_W = 8;
   localparam int TMO_CNT_W    = 16;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_PICK        = 3'd1,
      S_SETTLE      = 3'd2,
      S_CONVERT     = 3'd3,
      S_RELEASE     = 3'd4,
      S_WAIT_PERIOD = 3'd5
   } seq_state_t;

endpackage

// File: rtl/sar_scan_sequencer_if.sv
// Bus between the scan sequencer and its environment: scan control, the
// conversion FSM handshake and the tagged result stream.
interface sar_scan_sequencer_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2,
   parameter int DATA_W = 10
);
   import sar_seq_pkg::*;

   // Handshakes: run_conversion is a level request held until a 1-cycle
   // adc_done (adc_data valid in that cycle) or a timeout; result_valid and
   // scan_done are 1-cycle pulses with no backpressure from the consumer.
   logic                enable;
   logic                start;
   logic                continuous;
   logic [NUM_CH-1:0]   ch_mask;
   logic [PERIOD_W-1:0] period;
   logic                adc_done;
   logic [DATA_W-1:0]   adc_data;

   logic                run_conversion;
   logic [CH_W-1:0]     mux_sel;
   logic                result_valid;
   logic [CH_W-1:0]     result_ch;
   logic [DATA_W-1:0]   result_data;
   logic                scan_done;
   logic                busy;
   logic                timeout_err;

   modport master (
      input  enable, start, continuous, ch_mask, period, adc_done, adc_data,
      output run_conversion, mux_sel, result_valid, result_ch, result_data,
             scan_done, busy, timeout_err
   );

   modport slave (
      output enable, start, continuous, ch_mask, period, adc_done, adc_data,
      input  run_conversion, mux_sel, result_valid, result_ch, result_data,
             scan_done, busy, timeout_err
   );

endinterface

// File: rtl/sar_next_channel.sv
// Finds the lowest set mask bit strictly above last_ch, or the lowest set bit
// at all when first is high (start of a scan pass).
module sar_next_channel #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   last_ch,
   input  logic              first,
   output logic              found,
   output logic [CH_W-1:0]   ch
);

   // Walk downward so the last hit written is the lowest qualifying index.
   always_comb begin
      found = 1'b0;
      ch    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (first || (i > int'(last_ch)))) begin
            found = 1'b1;
            ch    = CH_W'(i);
         end
      end
   end

endmodule

// File: rtl/sar_scan_sequencer.sv
// Multi-channel scan controller for the SAR conversion FSM: walks a latched
// channel mask, settles the mux, runs one conversion per channel, posts results.
module sar_scan_sequencer
   import sar_seq_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int CH_W           = 2,
   parameter int DATA_W         = 10,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   sar_scan_sequencer_if.master  bus,
   output seq_state_t            dbg_state
);

   seq_state_t            state_q, state_d;
   logic [NUM_CH-1:0]     mask_q, mask_d;
   logic [CH_W-1:0]       last_ch_q, last_ch_d;
   logic                  first_q, first_d;
   logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [TMO_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [PERIOD_W-1:0]   period_cnt_q, period_cnt_d;

   logic                  run_q, run_d;
   logic [CH_W-1:0]       mux_sel_q, mux_sel_d;
   logic                  result_valid_q, result_valid_d;
   logic [CH_W-1:0]       result_ch_q, result_ch_d;
   logic [DATA_W-1:0]     result_data_q, result_data_d;
   logic                  scan_done_q, scan_done_d;
   logic                  busy_q, busy_d;
   logic                  timeout_q, timeout_d;

   logic                  nxt_found;
   logic [CH_W-1:0]       nxt_ch;

   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [TMO_CNT_W-1:0]    TMO_LAST    = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

   sar_next_channel #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_next_channel (
      .mask    (mask_q),
      .last_ch (last_ch_q),
      .first   (first_q),
      .found   (nxt_found),
      .ch      (nxt_ch)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         mask_q         <= '0;
         last_ch_q      <= '0;
         first_q        <= 1'b0;
         settle_cnt_q   <= '0;
         tmo_cnt_q      <= '0;
         period_cnt_q   <= '0;
         run_q          <= 1'b0;
         mux_sel_q      <= '0;
         result_valid_q <= 1'b0;
         result_ch_q    <= '0;
         result_data_q  <= '0;
         scan_done_q    <= 1'b0;
         busy_q         <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         last_ch_q      <= last_ch_d;
         first_q        <= first_d;
         settle_cnt_q   <= settle_cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
         period_cnt_q   <= period_cnt_d;
         run_q          <= run_d;
         mux_sel_q      <= mux_sel_d;
         result_valid_q <= result_valid_d;
         result_ch_q    <= result_ch_d;
         result_data_q  <= result_data_d;
         scan_done_q    <= scan_done_d;
         busy_q         <= busy_d;
         timeout_q      <= timeout_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      last_ch_d      = last_ch_q;
      first_d        = first_q;
      settle_cnt_d   = settle_cnt_q;
      tmo_cnt_d      = tmo_cnt_q;
      period_cnt_d   = period_cnt_q;
      run_d          = run_q;
      mux_sel_d      = mux_sel_q;
      result_valid_d = 1'b0;
      result_ch_d    = result_ch_q;
      result_data_d  = result_data_q;
      scan_done_d    = 1'b0;
      timeout_d      = timeout_q;

      // Start-to-start period timer; a scan start loads 1 so that the first
      // cycle of the next scan lands exactly 'period' cycles after this one.
      if ((state_q != S_IDLE) && (period_cnt_q != '1)) begin
         period_cnt_d = period_cnt_q + PERIOD_W'(1);
      end

      if (!bus.enable) begin
         state_d = S_IDLE;
         run_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // busy_q still high here only during the scan_done cycle
               if (bus.start && !busy_q) begin
                  mask_d       = bus.ch_mask;
                  timeout_d    = 1'b0;
                  period_cnt_d = PERIOD_W'(1);
                  first_d      = 1'b1;
                  state_d      = S_PICK;
               end
            end
            S_PICK: begin
               if (nxt_found) begin
                  mux_sel_d    = nxt_ch;
                  last_ch_d    = nxt_ch;
                  first_d      = 1'b0;
                  settle_cnt_d = '0;
                  state_d      = S_SETTLE;
               end else begin
                  scan_done_d = 1'b1;
                  state_d     = bus.continuous ? S_WAIT_PERIOD : S_IDLE;
               end
            end
            S_SETTLE: begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  run_d     = 1'b1;
                  tmo_cnt_d = '0;
                  state_d   = S_CONVERT;
               end else begin
                  settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
               end
            end
            S_CONVERT: begin
               if (bus.adc_done) begin
                  result_valid_d = 1'b1;
                  result_ch_d    = mux_sel_q;
                  result_data_d  = bus.adc_data;
                  run_d          = 1'b0;
                  state_d        = S_RELEASE;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  timeout_d = 1'b1;
                  run_d     = 1'b0;
                  state_d   = S_RELEASE;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
               end
            end
            S_RELEASE: begin
               state_d = S_PICK;
            end
            S_WAIT_PERIOD: begin
               if (period_cnt_q >= bus.period) begin
                  mask_d       = bus.ch_mask;
                  period_cnt_d = PERIOD_W'(1);
                  first_d      = 1'b1;
                  state_d      = S_PICK;
               end
            end
            default: begin
               state_d = S_IDLE;
               run_d   = 1'b0;
            end
         endcase
      end

      // Stay busy through the scan_done pulse so a start cannot overlap it.
      busy_d = (state_d != S_IDLE) || scan_done_d;
   end

   assign bus.run_conversion = run_q;
   assign bus.mux_sel        = mux_sel_q;
   assign bus.result_valid   = result_valid_q;
   assign bus.result_ch      = result_ch_q;
   assign bus.result_data    = result_data_q;
   assign bus.scan_done      = scan_done_q;
   assign bus.busy           = busy_q;
   assign bus.timeout_err    = timeout_q;
   assign dbg_state          = state_q;

endmodule
